// File: rtl/video_in_capture_ctrl.sv
// video_in_capture_ctrl
//   Sequences capture of composite-video samples into a ping-pong pair of
//   line buffers. It is driven by the sync separator's strobes. It tracks
//   lock (HUNT/TRACK/LOCKED), counts lines per field and detects field
//   parity. It produces line-buffer write strobes and addresses, and hands
//   each completed line downstream with a ready/ack handshake.
//
//   Optional feature: define VIDEO_IN_CAPTURE_WDOG_EN to enable an
//   h_sync-loss watchdog, and with it the WDOG_SAMPLES parameter.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   sample_valid    sample strobe; all video inputs are qualified by it
//   h_sync_pulse    line-start strobe
//   v_sync_pulse    frame-start strobe (wins over a coincident h_sync)
//   active_video    pixel-valid flag
//   line_ack        downstream consumed line_bank (not sample-qualified)
//   wr_en/wr_addr   line-buffer write strobe and address
//   wr_bank         bank currently being written
//   line_ready      completed line available in line_bank
//   line_num        active-line index of the ready line
//   line_len        samples written for the ready line
//   field           parity of the current field
//   locked          high while in LOCKED
//   overrun         one-cycle pulse when a completed line is dropped
module video_in_capture_ctrl #(
  parameter int unsigned LINE_LEN_MIN      = 2250,
  parameter int unsigned LINE_LEN_MAX      = 2450,
  parameter int unsigned HALF_LINE         = 1170,
  parameter int unsigned LINES_MIN         = 250,
  parameter int unsigned LINES_MAX         = 320,
  parameter int unsigned LOCK_FIELDS       = 2,
  parameter int unsigned ACTIVE_LINE_FIRST = 21,
  parameter int unsigned ACTIVE_LINES      = 240,
  parameter int unsigned ACTIVE_WIDTH      = 1280
`ifdef VIDEO_IN_CAPTURE_WDOG_EN
  , parameter int unsigned WDOG_SAMPLES    = 8192
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic        h_sync_pulse,
  input  logic        v_sync_pulse,
  input  logic        active_video,
  input  logic        line_ack,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic        wr_bank,
  output logic        line_ready,
  output logic        line_bank,
  output logic [7:0]  line_num,
  output logic [10:0] line_len,
  output logic        field,
  output logic        locked,
  output logic        overrun
);

  localparam logic [11:0] LEN_MIN  = 12'(LINE_LEN_MIN);
  localparam logic [11:0] LEN_MAX  = 12'(LINE_LEN_MAX);
  localparam logic [11:0] HALF     = 12'(HALF_LINE);
  localparam logic [8:0]  LN_MIN   = 9'(LINES_MIN);
  localparam logic [8:0]  LN_MAX   = 9'(LINES_MAX);
  localparam logic [8:0]  ACT_FIRST = 9'(ACTIVE_LINE_FIRST);
  localparam logic [8:0]  ACT_LAST = 9'(ACTIVE_LINE_FIRST + ACTIVE_LINES - 1);
  localparam logic [10:0] WIDTH    = 11'(ACTIVE_WIDTH);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FIELDS);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  good_cnt, good_cnt_nxt;
  logic [11:0] samp_cnt;
  logic [8:0]  line_cnt;
  logic [10:0] wr_cnt;

  logic vs, hs, field_good, interval_bad, in_window;
  logic leave_locked, line_done, accept, do_write, wdog_trip;

  // Strobes span two clocks but only one sample, so qualifying by
  // sample_valid counts each strobe exactly once.
  assign vs = sample_valid & v_sync_pulse;
  assign hs = sample_valid & h_sync_pulse & ~v_sync_pulse;

  assign field_good   = (line_cnt >= LN_MIN) && (line_cnt <= LN_MAX);
  assign interval_bad = hs && (line_cnt >= ACT_FIRST) &&
                        ((samp_cnt < LEN_MIN) || (samp_cnt > LEN_MAX));
  assign in_window    = (state == LOCKED) &&
                        (line_cnt >= ACT_FIRST) && (line_cnt <= ACT_LAST);

`ifdef VIDEO_IN_CAPTURE_WDOG_EN
  localparam logic [12:0] WD_LAST = 13'(WDOG_SAMPLES - 1);
  logic [12:0] wd_cnt;

  // Trips on the WDOG_SAMPLES-th sample with no h_sync; the >= keeps it
  // firing if the count already saturated while hunting.
  assign wdog_trip = sample_valid && !h_sync_pulse && (wd_cnt >= WD_LAST) &&
                     (state != HUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (sample_valid) begin
      if (h_sync_pulse)     wd_cnt <= '0;
      else if (wd_cnt != '1) wd_cnt <= wd_cnt + 13'd1;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    case (state)
      HUNT: begin
        if (vs) begin
          state_nxt    = TRACK;
          good_cnt_nxt = '0;
        end
      end
      TRACK: begin
        if (vs) begin
          if (field_good) begin
            good_cnt_nxt = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_N) state_nxt = LOCKED;
          end else begin
            good_cnt_nxt = '0;
          end
        end else if (interval_bad) begin
          state_nxt = HUNT;
        end
      end
      LOCKED: begin
        if (vs && !field_good) begin
          state_nxt    = TRACK;
          good_cnt_nxt = '0;
        end else if (interval_bad) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (wdog_trip) state_nxt = HUNT;
  end

  // A line ending on the same h_sync that loses lock is aborted, not handed on.
  assign leave_locked = (state == LOCKED) && (state_nxt != LOCKED);
  assign line_done    = hs && in_window && (wr_cnt != '0) && !leave_locked;
  assign accept       = line_done && (!line_ready || line_ack);
  assign do_write     = sample_valid && !h_sync_pulse && !v_sync_pulse &&
                        in_window && active_video && (wr_cnt < WIDTH) &&
                        !leave_locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      good_cnt   <= '0;
      samp_cnt   <= '0;
      line_cnt   <= '0;
      wr_cnt     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_bank    <= 1'b0;
      line_ready <= 1'b0;
      line_bank  <= 1'b0;
      line_num   <= '0;
      line_len   <= '0;
      field      <= 1'b0;
      locked     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      locked   <= (state_nxt == LOCKED);
      wr_en    <= do_write;
      overrun  <= line_done && !accept;

      if (sample_valid) begin
        if (hs || vs)            samp_cnt <= '0;
        else if (samp_cnt != '1) samp_cnt <= samp_cnt + 12'd1;
        if (vs)                           line_cnt <= '0;
        else if (hs && (line_cnt != '1))  line_cnt <= line_cnt + 9'd1;
        if (vs) field <= (samp_cnt > HALF);
      end

      // wr_addr carries the address of the write flagged by wr_en; wr_cnt
      // is the running count that becomes line_len.
      if (hs || vs || leave_locked) begin
        wr_cnt  <= '0;
        wr_addr <= '0;
      end else if (do_write) begin
        wr_addr <= wr_cnt;
        wr_cnt  <= wr_cnt + 11'd1;
      end

      if (leave_locked) begin
        line_ready <= 1'b0;
      end else if (accept) begin
        line_ready <= 1'b1;
        line_bank  <= wr_bank;
        line_num   <= 8'(line_cnt - ACT_FIRST);
        line_len   <= wr_cnt;
        wr_bank    <= ~wr_bank;
      end else if (line_ack) begin
        line_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_in_capture_ctrl.sv
// Testbench for video_in_capture_ctrl. Runs with scaled-down timing
// parameters so whole fields fit in a short simulation, drives randomized
// fields of sync/active-video samples, and compares every output on every
// clock against a behavioural model of the capture rules.
module tb_video_in_capture_ctrl;

  localparam int LLMIN = 90;
  localparam int LLMAX = 110;
  localparam int HALF  = 50;
  localparam int LNMIN = 10;
  localparam int LNMAX = 14;
  localparam int LOCKN = 2;
  localparam int FIRST = 3;
  localparam int NACT  = 6;
  localparam int W     = 64;
  localparam int WDOG  = 256;

  logic        clk = 1'b0;
  logic        rst, sample_valid, h_sync_pulse, v_sync_pulse, active_video, line_ack;
  logic        wr_en, wr_bank, line_ready, line_bank, field, locked, overrun;
  logic [10:0] wr_addr, line_len;
  logic [7:0]  line_num;

  video_in_capture_ctrl #(
    .LINE_LEN_MIN(LLMIN), .LINE_LEN_MAX(LLMAX), .HALF_LINE(HALF),
    .LINES_MIN(LNMIN), .LINES_MAX(LNMAX), .LOCK_FIELDS(LOCKN),
    .ACTIVE_LINE_FIRST(FIRST), .ACTIVE_LINES(NACT), .ACTIVE_WIDTH(W)
`ifdef VIDEO_IN_CAPTURE_WDOG_EN
    , .WDOG_SAMPLES(WDOG)
`endif
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .h_sync_pulse(h_sync_pulse), .v_sync_pulse(v_sync_pulse),
    .active_video(active_video), .line_ack(line_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .line_ready(line_ready), .line_bank(line_bank), .line_num(line_num),
    .line_len(line_len), .field(field), .locked(locked), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int ack_mode;  // 0 never, 1 random, 2 only on h_sync samples

  // Reference model: mode 0 = hunting, 1 = tracking, 2 = locked.
  int m_mode, m_scnt, m_lcnt, m_wcnt, m_good, m_wd;
  int e_wr_addr, e_line_num, e_line_len;
  bit e_wr_en, e_wr_bank, e_ready, e_bank, e_field, e_locked, e_overrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_scnt = 0; m_lcnt = 0; m_wcnt = 0; m_good = 0; m_wd = 0;
    e_wr_addr = 0; e_line_num = 0; e_line_len = 0;
    e_wr_en = 0; e_wr_bank = 0; e_ready = 0; e_bank = 0;
    e_field = 0; e_locked = 0; e_overrun = 0;
  endtask

  task automatic model_step(input bit sv, input bit h, input bit v, input bit av, input bit ack);
    int nmode;
    bit hsy, vsy, leave, inwin, done, wr, fgood;
    nmode = m_mode; leave = 0; done = 0; wr = 0;
    e_wr_en = 0; e_overrun = 0;
    if (sv) begin
      vsy   = v;
      hsy   = h && !v;
      inwin = (m_mode == 2) && (m_lcnt >= FIRST) && (m_lcnt <= FIRST + NACT - 1);
      if (vsy) begin
        fgood   = (m_lcnt >= LNMIN) && (m_lcnt <= LNMAX);
        e_field = (m_scnt > HALF);
        if (m_mode == 0) begin
          nmode = 1; m_good = 0;
        end else if (m_mode == 1) begin
          if (fgood) begin
            m_good++;
            if (m_good == LOCKN) nmode = 2;
          end else m_good = 0;
        end else if (!fgood) begin
          nmode = 1; m_good = 0;
        end
      end else if (hsy && m_mode != 0 && m_lcnt >= FIRST &&
                   (m_scnt < LLMIN || m_scnt > LLMAX)) begin
        nmode = 0;
      end
`ifdef VIDEO_IN_CAPTURE_WDOG_EN
      if (h) m_wd = 0;
      else begin
        if (m_wd < 8191) m_wd++;
        if (m_wd >= WDOG && m_mode != 0) nmode = 0;
      end
`endif
      leave = (m_mode == 2) && (nmode != 2);
      done  = hsy && inwin && (m_wcnt > 0) && !leave;
      wr    = !h && !v && inwin && av && (m_wcnt < W) && !leave;
      if (done) begin
        if (!e_ready || ack) begin
          e_ready = 1; e_bank = e_wr_bank; e_line_num = m_lcnt - FIRST;
          e_line_len = m_wcnt; e_wr_bank = !e_wr_bank;
        end else e_overrun = 1;
      end else if (ack) e_ready = 0;
      if (leave) e_ready = 0;
      if (hsy || vsy) m_scnt = 0;
      else if (m_scnt < 4095) m_scnt++;
      if (vsy) m_lcnt = 0;
      else if (hsy && m_lcnt < 511) m_lcnt++;
      if (hsy || vsy || leave) begin
        m_wcnt = 0; e_wr_addr = 0;
      end else if (wr) begin
        e_wr_en = 1; e_wr_addr = m_wcnt; m_wcnt++;
      end
    end else if (ack) e_ready = 0;
    m_mode   = nmode;
    e_locked = (m_mode == 2);
  endtask

  task automatic compare_all();
    check("wr_en",      32'(wr_en),      32'(e_wr_en));
    check("wr_addr",    32'(wr_addr),    32'(e_wr_addr));
    check("wr_bank",    32'(wr_bank),    32'(e_wr_bank));
    check("line_ready", 32'(line_ready), 32'(e_ready));
    check("line_bank",  32'(line_bank),  32'(e_bank));
    check("line_num",   32'(line_num),   32'(e_line_num));
    check("line_len",   32'(line_len),   32'(e_line_len));
    check("field",      32'(field),      32'(e_field));
    check("locked",     32'(locked),     32'(e_locked));
    check("overrun",    32'(overrun),    32'(e_overrun));
  endtask

  task automatic cycle(input bit sv, input bit h, input bit v, input bit av);
    bit a;
    case (ack_mode)
      0:       a = 0;
      1:       a = ($urandom_range(0, 3) == 0);
      default: a = sv && h && !v;
    endcase
    sample_valid = sv; h_sync_pulse = h; v_sync_pulse = v;
    active_video = av; line_ack = a;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(sv, h, v, av, a);
    #1;
    compare_all();
  endtask

  // One sample: strobes held for two clocks, sample_valid on the first.
  task automatic do_sample(input bit h, input bit v, input bit av);
    cycle(1'b1, h, v, av);
    cycle(1'b0, h, v, av);
  endtask

  task automatic plain(input int n);
    repeat (n) do_sample(1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync(input bit coincide);
    do_sample(coincide, 1'b1, 1'b0);
  endtask

  // h_sync sample followed by len-1 samples; active video from sample 2.
  task automatic one_line(input int len, input int acnt);
    do_sample(1'b1, 1'b0, 1'b0);
    for (int s = 1; s < len; s++) do_sample(1'b0, 1'b0, (s >= 2) && (s < 2 + acnt));
  endtask

  task automatic field_body(input int nlines, input int tail, input int bad_at);
    int len, acnt;
    plain(5);
    for (int i = 0; i < nlines; i++) begin
      if (i == nlines - 1)  len = tail + 1;
      else if (i == bad_at) len = 71;
      else                  len = $urandom_range(LLMIN + 1, LLMAX + 1);
      acnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(W - 8, W + 8);
      one_line(len, acnt);
    end
  endtask

  initial begin
    int nl, bad;
    model_reset();
    ack_mode = 1;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_ready",  32'(line_ready), 32'd0);
    rst = 1'b0;

    // Lock: first v_sync leaves HUNT, then two good fields.
    repeat (2) begin vsync(1'b0); field_body(12, 60, -1); end
    vsync(1'b0);
    check("locked_after_good_fields", 32'(locked), 32'd1);
    field_body(12, 60, -1);

    // Ack withheld: later completions are dropped with overrun.
    ack_mode = 0;
    vsync(1'b0); field_body(12, 60, -1);
    check("ready_held_without_ack", 32'(line_ready), 32'd1);

    // Ack coincident with every completion.
    ack_mode = 2;
    vsync(1'b0); field_body(12, 60, -1);

    // Field parity from the last line's tail length.
    ack_mode = 1;
    vsync(1'b0); field_body(12, 10, -1);
    vsync(1'b0);
    check("field_short_tail", 32'(field), 32'd0);
    field_body(12, 60, -1);
    vsync(1'b0);
    check("field_long_tail", 32'(field), 32'd1);

    // Short line mid-field while locked.
    field_body(12, 60, 5);
    check("bad_line_unlocked", 32'(locked), 32'd0);
    check("bad_line_ready", 32'(line_ready), 32'd0);

    repeat (3) begin vsync(1'b0); field_body(12, 60, -1); end
    check("relocked", 32'(locked), 32'd1);

    // Syncs stop while locked.
    plain(300);
`ifdef VIDEO_IN_CAPTURE_WDOG_EN
    check("nosync_locked", 32'(locked), 32'd0);
`else
    check("nosync_locked", 32'(locked), 32'd1);
`endif

    // Randomized fields: odd line counts, bad lines, coincident syncs.
    repeat (6) begin
      nl  = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 5 : 18)
                                        : $urandom_range(LNMIN, LNMAX);
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 8) : -1;
      vsync($urandom_range(0, 3) == 0);
      field_body(nl, ($urandom_range(0, 1) == 0) ? 10 : 60, bad);
    end

    // Reset in the middle of a captured line.
    repeat (3) begin vsync(1'b0); field_body(12, 60, -1); end
    vsync(1'b0); plain(5);
    one_line(95, 64); one_line(95, 64); one_line(95, 64); one_line(95, 64);
    one_line(40, 30);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check("midline_reset_locked", 32'(locked), 32'd0);
    check("midline_reset_bank", 32'(wr_bank), 32'd0);
    repeat (3) begin vsync(1'b0); field_body(12, 60, -1); end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
